// File: rtl/lapido_pkg.sv
// Lapido instruction-format definitions shared by the encoder and the control decoder:
// class codes, request types, opcode constants, legality check and field packing.
package lapido_pkg;

  typedef enum logic [2:0] {
    CLS_NOP   = 3'b000,
    CLS_ALU   = 3'b001,
    CLS_CONST = 3'b010,
    CLS_MEM   = 3'b100
  } instrClass_e;

  typedef enum logic [1:0] {
    REQ_NOP   = 2'd0,
    REQ_ALU   = 2'd1,
    REQ_MEM   = 2'd2,
    REQ_CONST = 2'd3
  } reqType_e;

  localparam logic [4:0] ALU_ADD      = 5'b00000;
  localparam logic [4:0] ALU_SUB      = 5'b00001;
  localparam logic [4:0] ALU_AND      = 5'b00011;
  localparam logic [4:0] ALU_OR       = 5'b00100;
  localparam logic [4:0] ALU_XOR      = 5'b00101;
  localparam logic [4:0] ALU_NOT      = 5'b00110;
  localparam logic [4:0] ALU_SHL      = 5'b01000;
  localparam logic [4:0] ALU_SHR      = 5'b01001;
  localparam logic [4:0] ALU_EXT_BASE = 5'b10000;

  localparam logic [4:0] MEM_LOAD      = 5'b00000;
  localparam logic [4:0] MEM_STORE     = 5'b00001;
  localparam logic [4:0] CONST_LOADLIT = 5'b00010;

  function automatic logic isLegal(reqType_e t, logic [4:0] op);
    logic ok;
    ok = 1'b0;
    case (t)
      REQ_NOP:   ok = 1'b1;
      REQ_ALU:   ok = op[4] || (op inside {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
                                           ALU_XOR, ALU_NOT, ALU_SHL, ALU_SHR});
      REQ_MEM:   ok = (op == MEM_LOAD) || (op == MEM_STORE);
      REQ_CONST: ok = (op == CONST_LOADLIT);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] encode(reqType_e t, logic [4:0] op, logic [3:0] rd,
                                         logic [3:0] ra, logic [3:0] rb, logic [15:0] imm);
    logic [31:0] w;
    w = '0;
    case (t)
      REQ_ALU:   w = {CLS_ALU, op, rd, ra, rb, 12'h000};
      REQ_MEM:   w = {CLS_MEM, op, rd, ra, imm};
      REQ_CONST: w = {CLS_CONST, op, rd, ra, imm};
      default:   w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lapido_instr_encoder_if.sv
// Request and instruction handshake bundle of the Lapido encoder.
interface lapido_instr_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_type;
  logic [4:0]  req_op;
  logic [3:0]  req_rd;
  logic [3:0]  req_ra;
  logic [3:0]  req_rb;
  logic [15:0] req_imm;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;

  modport master (
    output req_valid, req_type, req_op, req_rd, req_ra, req_rb, req_imm, instr_ready,
    input  req_ready, instr_valid, instruction
  );

  modport slave (
    input  req_valid, req_type, req_op, req_rd, req_ra, req_rb, req_imm, instr_ready,
    output req_ready, instr_valid, instruction
  );
endinterface

// File: rtl/lapido_instr_fifo.sv
// Synchronous DEPTH x WIDTH FIFO with occupancy count; control state clears on async reset.
module lapido_instr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         pushData,
  output logic [WIDTH-1:0]         headData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W:0]   count;
  logic             doPush;
  logic             doPop;

  assign full     = (count == FULL_LEVEL);
  assign empty    = (count == '0);
  assign level    = count;
  assign headData = mem[rdPtr];
  assign doPush   = push & ~full;
  assign doPop    = pop & ~empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr] <= pushData;
  end
endmodule

// File: rtl/lapido_instr_encoder.sv
// Lapido instruction encoder: packs field requests into words, buffers them, drops illegal ops.
// Optional LAPIDO_ENC_NOP_FILL_EN: present a NOP whenever the buffer is empty.
module lapido_instr_encoder
  import lapido_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  lapido_instr_encoder_if.slave  bus,
  output logic                   illegal,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       issued_count
);
  logic        reqLegal;
  logic        accept;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic [31:0] word;
  logic [31:0] headData;

  assign reqLegal      = isLegal(reqType_e'(bus.req_type), bus.req_op);
  assign word          = encode(reqType_e'(bus.req_type), bus.req_op, bus.req_rd,
                                bus.req_ra, bus.req_rb, bus.req_imm);
  assign bus.req_ready = ~full;
  assign accept        = bus.req_valid & bus.req_ready;
  assign push          = accept & reqLegal;
  // A fill NOP is never a real pop, so empty gates the pop here.
  assign pop           = bus.instr_ready & ~empty;

  lapido_instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .pushData (word),
    .headData (headData),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );

  assign bus.instruction = empty ? '0 : headData;
`ifdef LAPIDO_ENC_NOP_FILL_EN
  assign bus.instr_valid = ~empty | ~reset;
`else
  assign bus.instr_valid = ~empty;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      illegal      <= 1'b0;
      issued_count <= '0;
    end else begin
      illegal <= accept & ~reqLegal;
      if (pop) issued_count <= issued_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_lapido_instr_encoder.sv
// Self-checking bench for lapido_instr_encoder: directed scenarios plus randomized traffic vs a queue model.
module tb_lapido_instr_encoder;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 4;
`ifdef LAPIDO_ENC_NOP_FILL_EN
  localparam logic FILL = 1'b1;
`else
  localparam logic FILL = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             illegal;
  logic [2:0]       level;
  logic [CNT_W-1:0] issued_count;
  int compared   = 0;
  int mismatched = 0;

  lapido_instr_encoder_if bus();

  lapido_instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .illegal      (illegal),
    .level        (level),
    .issued_count (issued_count)
  );

  always #5 clock = ~clock;

  function automatic bit refLegal(int t, int op);
    case (t)
      0: return 1'b1;
      1: return (op >= 16) || (op inside {0, 1, 3, 4, 5, 6, 8, 9});
      2: return op <= 1;
      3: return op == 2;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] refEncode(int t, int op, int rd, int ra, int rb, int imm);
    int unsigned cls;
    int unsigned w;
    case (t)
      1: cls = 1;
      2: cls = 4;
      3: cls = 2;
      default: return 32'h0;
    endcase
    w = cls * 32'h2000_0000 + op * 32'h0100_0000 + rd * 32'h0010_0000 + ra * 32'h0001_0000;
    w = w + ((t == 1) ? rb * 4096 : imm);
    return w;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.req_type  = 2'd0;
    bus.req_op    = 5'd0;
    bus.req_rd    = 4'd0;
    bus.req_ra    = 4'd0;
    bus.req_rb    = 4'd0;
    bus.req_imm   = 16'd0;
  endtask

  task automatic drive(input int t, input int op, input int rd, input int ra, input int rb, input int imm);
    bus.req_valid = 1'b1;
    bus.req_type  = 2'(t);
    bus.req_op    = 5'(op);
    bus.req_rd    = 4'(rd);
    bus.req_ra    = 4'(ra);
    bus.req_rb    = 4'(rb);
    bus.req_imm   = 16'(imm);
  endtask

  task automatic test_reset();
    idle();
    bus.instr_ready = 1'b0;
    reset = 1'b1;
    tick();
    compared++; if (bus.req_ready !== 1'b1) begin mismatched++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
    compared++; if (bus.instr_valid !== 1'b0) begin mismatched++; $display("FAIL reset_instr_valid got=%b exp=0", bus.instr_valid); end
    compared++; if (bus.instruction !== 32'h0) begin mismatched++; $display("FAIL reset_instruction got=%h exp=0", bus.instruction); end
    compared++; if ({illegal, level, issued_count} !== '0) begin mismatched++; $display("FAIL reset_status got=%b/%0d/%0d exp=0/0/0", illegal, level, issued_count); end
    reset = 1'b0;
    #1;
    compared++; if (bus.instr_valid !== FILL) begin mismatched++; $display("FAIL idle_instr_valid got=%b exp=%b", bus.instr_valid, FILL); end
  endtask

  task automatic test_alu_add();
    bus.instr_ready = 1'b1;
    drive(1, 0, 3, 1, 2, 0);
    tick();
    idle();
    compared++; if (bus.instr_valid !== 1'b1) begin mismatched++; $display("FAIL alu_valid got=%b exp=1", bus.instr_valid); end
    compared++; if (bus.instruction !== 32'h2031_2000) begin mismatched++; $display("FAIL alu_word got=%h exp=20312000", bus.instruction); end
    compared++; if (level !== 3'd1) begin mismatched++; $display("FAIL alu_level got=%0d exp=1", level); end
    tick();
    compared++; if (issued_count !== 4'd1) begin mismatched++; $display("FAIL alu_count got=%0d exp=1", issued_count); end
    compared++; if (level !== 3'd0 || bus.instr_valid !== FILL) begin mismatched++; $display("FAIL alu_drained got=%0d/%b exp=0/%b", level, bus.instr_valid, FILL); end
  endtask

  task automatic test_mem_const();
    bus.instr_ready = 1'b0;
    drive(2, 1, 5, 2, 0, 16'h0010);
    tick();
    drive(3, 2, 7, 0, 0, 16'hBEEF);
    tick();
    idle();
    compared++; if (level !== 3'd2) begin mismatched++; $display("FAIL memconst_level got=%0d exp=2", level); end
    compared++; if (bus.instruction !== 32'h8152_0010) begin mismatched++; $display("FAIL mem_word got=%h exp=81520010", bus.instruction); end
    bus.instr_ready = 1'b1;
    tick();
    compared++; if (bus.instruction !== 32'h4270_BEEF) begin mismatched++; $display("FAIL const_word got=%h exp=4270beef", bus.instruction); end
    tick();
    compared++; if (level !== 3'd0 || issued_count !== 4'd3) begin mismatched++; $display("FAIL memconst_end got=%0d/%0d exp=0/3", level, issued_count); end
  endtask

  task automatic test_illegal();
    bus.instr_ready = 1'b1;
    drive(1, 2, 1, 1, 1, 0);
    tick();
    idle();
    compared++; if (illegal !== 1'b1) begin mismatched++; $display("FAIL illegal_pulse got=%b exp=1", illegal); end
    compared++; if (level !== 3'd0 || bus.instr_valid !== FILL) begin mismatched++; $display("FAIL illegal_dropped got=%0d/%b exp=0/%b", level, bus.instr_valid, FILL); end
    tick();
    compared++; if (illegal !== 1'b0) begin mismatched++; $display("FAIL illegal_one_cycle got=%b exp=0", illegal); end
    compared++; if (issued_count !== 4'd3) begin mismatched++; $display("FAIL illegal_count got=%0d exp=3", issued_count); end
  endtask

  task automatic test_full_backpressure();
    logic [31:0] words [5];
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 16 + i, i, i + 1, i + 2, 0);
      words[i] = refEncode(1, 16 + i, i, i + 1, i + 2, 0);
      compared++; if (bus.req_ready !== (i < 4)) begin mismatched++; $display("FAIL full_req_ready[%0d] got=%b exp=%b", i, bus.req_ready, (i < 4)); end
      tick();
    end
    idle();
    compared++; if (level !== 3'd4 || bus.req_ready !== 1'b0) begin mismatched++; $display("FAIL full_state got=%0d/%b exp=4/0", level, bus.req_ready); end
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      compared++; if (bus.instruction !== words[i]) begin mismatched++; $display("FAIL full_drain[%0d] got=%h exp=%h", i, bus.instruction, words[i]); end
      tick();
    end
    compared++; if (level !== 3'd0 || issued_count !== 4'd7) begin mismatched++; $display("FAIL full_end got=%0d/%0d exp=0/7", level, issued_count); end
  endtask

  task automatic test_reset_mid_drain();
    logic [31:0] w;
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(2, 0, i, 15 - i, 0, 16'h1000 + i);
      tick();
    end
    bus.instr_ready = 1'b1;
    drive(2, 1, 9, 9, 0, 16'h0009);
    tick();
    #2;
    reset = 1'b1;
    #1;
    compared++; if (bus.req_ready !== 1'b1 || bus.instr_valid !== 1'b0 || bus.instruction !== 32'h0) begin mismatched++; $display("FAIL midreset_bus got=%b/%b/%h exp=1/0/0", bus.req_ready, bus.instr_valid, bus.instruction); end
    compared++; if ({illegal, level, issued_count} !== '0) begin mismatched++; $display("FAIL midreset_status got=%b/%0d/%0d exp=0/0/0", illegal, level, issued_count); end
    tick();
    compared++; if (level !== 3'd0) begin mismatched++; $display("FAIL midreset_discard got=%0d exp=0", level); end
    reset = 1'b0;
    bus.instr_ready = 1'b0;
    drive(3, 2, 4, 0, 0, 16'h1234);
    w = refEncode(3, 2, 4, 0, 0, 16'h1234);
    tick();
    idle();
    compared++; if (level !== 3'd1 || bus.instruction !== w) begin mismatched++; $display("FAIL postreset_push got=%0d/%h exp=1/%h", level, bus.instruction, w); end
    bus.instr_ready = 1'b1;
    tick();
    compared++; if (issued_count !== 4'd1 || level !== 3'd0) begin mismatched++; $display("FAIL postreset_pop got=%0d/%0d exp=1/0", issued_count, level); end
  endtask

  task automatic test_nop_fill();
    logic [31:0] w;
    idle();
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++; if (bus.instr_valid !== FILL || bus.instruction !== 32'h0) begin mismatched++; $display("FAIL fill_idle[%0d] got=%b/%h exp=%b/0", i, bus.instr_valid, bus.instruction, FILL); end
      compared++; if (issued_count !== 4'd1) begin mismatched++; $display("FAIL fill_count[%0d] got=%0d exp=1", i, issued_count); end
    end
    bus.instr_ready = 1'b0;
    drive(1, 9, 2, 3, 4, 0);
    w = refEncode(1, 9, 2, 3, 4, 0);
    tick();
    idle();
    compared++; if (bus.instr_valid !== 1'b1 || bus.instruction !== w) begin mismatched++; $display("FAIL fill_priority got=%b/%h exp=1/%h", bus.instr_valid, bus.instruction, w); end
  endtask

  task automatic test_random();
    logic [31:0] q [$];
    int cnt;
    bit expIll;
    int t, op, rd, ra, rb, imm;
    bit v, r, acc;
    logic [31:0] expWord;
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cnt = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      v   = ($urandom_range(0, 9) < 7);
      r   = ($urandom_range(0, 1) == 1);
      t   = $urandom_range(0, 3);
      op  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, 31);
      rd  = $urandom_range(0, 15);
      ra  = $urandom_range(0, 15);
      rb  = $urandom_range(0, 15);
      imm = $urandom_range(0, 65535);
      if (v) drive(t, op, rd, ra, rb, imm); else idle();
      bus.instr_ready = r;
      acc = v && (q.size() < DEPTH);
      if (r && q.size() > 0) begin
        void'(q.pop_front());
        cnt = (cnt + 1) % 16;
      end
      if (acc && refLegal(t, op)) q.push_back(refEncode(t, op, rd, ra, rb, imm));
      expIll = acc && !refLegal(t, op);
      tick();
      expWord = (q.size() > 0) ? q[0] : 32'h0;
      compared++; if (level !== 3'(q.size())) begin mismatched++; $display("FAIL rnd_level[%0d] got=%0d exp=%0d", cyc, level, q.size()); end
      compared++; if (bus.instr_valid !== ((q.size() > 0) || FILL)) begin mismatched++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", cyc, bus.instr_valid, (q.size() > 0) || FILL); end
      compared++; if (bus.instruction !== expWord) begin mismatched++; $display("FAIL rnd_word[%0d] got=%h exp=%h", cyc, bus.instruction, expWord); end
      compared++; if (illegal !== expIll) begin mismatched++; $display("FAIL rnd_illegal[%0d] got=%b exp=%b", cyc, illegal, expIll); end
      compared++; if (issued_count !== 4'(cnt)) begin mismatched++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", cyc, issued_count, cnt); end
      compared++; if (bus.req_ready !== (q.size() < DEPTH)) begin mismatched++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", cyc, bus.req_ready, q.size() < DEPTH); end
    end
  endtask

  initial begin
    idle();
    bus.instr_ready = 1'b0;
    test_reset();
    test_alu_add();
    test_mem_const();
    test_illegal();
    test_full_backpressure();
    test_reset_mid_drain();
    test_nop_fill();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
